// File: rtl/dmem_store_buffer.sv
// Posted-write buffer between the processor data port and dmem: stores are queued
// in a small FIFO and retired when the port is idle; loads hitting a pending word stall.
module dmem_store_buffer #(
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [0:31]      addr_from_proc,
   input  logic [0:31]      data_from_proc,
   input  logic             write_enable_from_proc,
   input  logic             read_enable_from_proc,
   input  logic             byte_from_proc,
   input  logic             half_word_from_proc,
   input  logic             sign_extend_from_proc,
   output logic [0:31]      data_to_proc,
   output logic             stall_to_proc,
   output logic [0:31]      addr_to_mem,
   output logic [0:31]      data_to_mem,
   output logic             write_enable_to_mem,
   output logic             byte_to_mem,
   output logic             half_word_to_mem,
   output logic             sign_extend_to_mem,
   input  logic [0:31]      data_from_mem,
   output logic [CNT_W-1:0] count,
   output logic             empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [0:31]      addr_q_r [DEPTH];
   logic [0:31]      data_q_r [DEPTH];
   logic [DEPTH-1:0] byte_q_r;
   logic [DEPTH-1:0] half_q_r;
   logic [DEPTH-1:0] valid_r;
   logic [PTR_W-1:0] head_r;
   logic [PTR_W-1:0] tail_r;
   logic [CNT_W-1:0] count_r;
   logic             empty_r;

   logic             full_s;
   logic             conflict_s;
   logic             enq_s;
   logic             deq_s;
   logic [CNT_W-1:0] count_next_s;

   function automatic logic word_match(input logic [0:31] a, input logic [0:31] b);
      return a[0:29] == b[0:29];
   endfunction

   assign data_to_proc = data_from_mem;
   assign count        = count_r;
   assign empty        = empty_r;
   assign full_s       = (count_r == CNT_W'(DEPTH));

   // Scan every live entry for a word-address hit against the current request
   always_comb begin
      conflict_s = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         conflict_s = conflict_s | (valid_r[i] & word_match(addr_q_r[i], addr_from_proc));
      end
   end

   // Per-cycle arbitration of the dmem port; a simultaneous read+write is a store
   always_comb begin
      enq_s         = 1'b0;
      deq_s         = 1'b0;
      stall_to_proc = 1'b0;
      if (reset) begin
         enq_s = 1'b0;
      end else if (write_enable_from_proc) begin
         if (full_s) begin
            stall_to_proc = 1'b1;
            deq_s         = 1'b1;
         end else begin
            enq_s = 1'b1;
         end
      end else if (read_enable_from_proc) begin
         if (conflict_s) begin
            stall_to_proc = 1'b1;
            deq_s         = 1'b1;
         end else begin
            deq_s = 1'b0;
         end
      end else begin
         deq_s = (count_r != CNT_W'(0));
      end

      addr_to_mem         = addr_from_proc;
      data_to_mem         = data_from_proc;
      byte_to_mem         = byte_from_proc;
      half_word_to_mem    = half_word_from_proc;
      sign_extend_to_mem  = sign_extend_from_proc;
      write_enable_to_mem = 1'b0;
      if (deq_s) begin
         addr_to_mem         = addr_q_r[head_r];
         data_to_mem         = data_q_r[head_r];
         byte_to_mem         = byte_q_r[head_r];
         half_word_to_mem    = half_q_r[head_r];
         sign_extend_to_mem  = 1'b0;
         write_enable_to_mem = 1'b1;
      end else begin
         write_enable_to_mem = 1'b0;
      end
   end

   // Occupancy bookkeeping; enqueue and dequeue are mutually exclusive
   always_comb begin
      count_next_s = count_r;
      if (enq_s) begin
         count_next_s = count_r + CNT_W'(1);
      end else if (deq_s) begin
         count_next_s = count_r - CNT_W'(1);
      end else begin
         count_next_s = count_r;
      end
   end

   // FIFO storage, pointers and registered status
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         head_r   <= {PTR_W{1'b0}};
         tail_r   <= {PTR_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
         empty_r  <= 1'b1;
         valid_r  <= {DEPTH{1'b0}};
         byte_q_r <= {DEPTH{1'b0}};
         half_q_r <= {DEPTH{1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            addr_q_r[i] <= 32'h0000_0000;
            data_q_r[i] <= 32'h0000_0000;
         end
      end else begin
         if (enq_s) begin
            addr_q_r[tail_r] <= addr_from_proc;
            data_q_r[tail_r] <= data_from_proc;
            byte_q_r[tail_r] <= byte_from_proc;
            half_q_r[tail_r] <= half_word_from_proc;
            valid_r[tail_r]  <= 1'b1;
            tail_r           <= tail_r + PTR_W'(1);
         end else if (deq_s) begin
            valid_r[head_r] <= 1'b0;
            head_r          <= head_r + PTR_W'(1);
         end else begin
            head_r <= head_r;
         end
         count_r <= count_next_s;
         empty_r <= (count_next_s == CNT_W'(0));
      end
   end

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Self-checking bench for dmem_store_buffer: directed scenarios plus random traffic
// against a queue-based model of pending stores and a byte-array model of dmem.
module tb_dmem_store_buffer;

   localparam int DEPTH = 4;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic             clock = 1'b0;
   logic             reset;
   logic [0:31]      addr_from_proc, data_from_proc, data_to_proc;
   logic             write_enable_from_proc, read_enable_from_proc;
   logic             byte_from_proc, half_word_from_proc, sign_extend_from_proc;
   logic             stall_to_proc;
   logic [0:31]      addr_to_mem, data_to_mem, data_from_mem;
   logic             write_enable_to_mem, byte_to_mem, half_word_to_mem, sign_extend_to_mem;
   logic [CNT_W-1:0] count;
   logic             empty;

   dmem_store_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clock(clock), .reset(reset),
      .addr_from_proc(addr_from_proc), .data_from_proc(data_from_proc),
      .write_enable_from_proc(write_enable_from_proc), .read_enable_from_proc(read_enable_from_proc),
      .byte_from_proc(byte_from_proc), .half_word_from_proc(half_word_from_proc),
      .sign_extend_from_proc(sign_extend_from_proc),
      .data_to_proc(data_to_proc), .stall_to_proc(stall_to_proc),
      .addr_to_mem(addr_to_mem), .data_to_mem(data_to_mem),
      .write_enable_to_mem(write_enable_to_mem), .byte_to_mem(byte_to_mem),
      .half_word_to_mem(half_word_to_mem), .sign_extend_to_mem(sign_extend_to_mem),
      .data_from_mem(data_from_mem), .count(count), .empty(empty)
   );

   always #5 clock = ~clock;

   logic [7:0] dut_mem [0:65535];
   logic [7:0] ref_mem [0:65535];
   int passes = 0;
   int total  = 0;

   typedef struct {logic [31:0] a; logic [31:0] d; logic b; logic h;} st_t;
   st_t q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic put(input bit to_ref, input logic [15:0] i, input logic [7:0] v);
      if (to_ref) ref_mem[i] = v;
      else dut_mem[i] = v;
   endtask

   // Big-endian dmem: byte/half stores take the low lanes of the data word
   task automatic mem_wr(input bit to_ref, input logic [31:0] a, input logic [31:0] d,
                         input logic b, input logic h);
      logic [15:0] i;
      i = a[15:0];
      if (b) begin
         put(to_ref, i, d[7:0]);
      end else if (h) begin
         i[0] = 1'b0;
         put(to_ref, i, d[15:8]);
         put(to_ref, i + 16'd1, d[7:0]);
      end else begin
         i[1:0] = 2'b00;
         put(to_ref, i, d[31:24]);
         put(to_ref, i + 16'd1, d[23:16]);
         put(to_ref, i + 16'd2, d[15:8]);
         put(to_ref, i + 16'd3, d[7:0]);
      end
   endtask

   function automatic logic [31:0] rd_word(input bit from_ref, input logic [31:0] a);
      logic [15:0] i;
      i = {a[15:2], 2'b00};
      if (from_ref) return {ref_mem[i], ref_mem[i+16'd1], ref_mem[i+16'd2], ref_mem[i+16'd3]};
      else return {dut_mem[i], dut_mem[i+16'd1], dut_mem[i+16'd2], dut_mem[i+16'd3]};
   endfunction

   always @(posedge clock) begin
      if (write_enable_to_mem) mem_wr(1'b0, addr_to_mem, data_to_mem, byte_to_mem, half_word_to_mem);
   end

   // One processor cycle: drive, check combinational outputs, step the model, check count
   task automatic cyc(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d,
                      input logic b, input logic h, input logic s, output logic stalled);
      logic exp_drain, exp_stall, exp_enq, conf;
      st_t hd;
      write_enable_from_proc = w;
      read_enable_from_proc  = r;
      addr_from_proc         = a;
      data_from_proc         = d;
      byte_from_proc         = b;
      half_word_from_proc    = h;
      sign_extend_from_proc  = s;
      #1;
      data_from_mem = rd_word(1'b0, addr_to_mem);
      #1;
      conf = 1'b0;
      foreach (q[k]) if (q[k].a[31:2] == a[31:2]) conf = 1'b1;
      exp_enq = 1'b0; exp_drain = 1'b0; exp_stall = 1'b0;
      if (w) begin
         if (q.size() == DEPTH) begin exp_stall = 1'b1; exp_drain = 1'b1; end
         else exp_enq = 1'b1;
      end else if (r) begin
         if (conf) begin exp_stall = 1'b1; exp_drain = 1'b1; end
      end else begin
         exp_drain = (q.size() > 0);
      end
      chk("stall", stall_to_proc, exp_stall);
      chk("wen", write_enable_to_mem, exp_drain);
      if (exp_drain) begin
         hd = q[0];
         chk("drain_addr", addr_to_mem, hd.a);
         chk("drain_data", data_to_mem, hd.d);
         chk("drain_byte", byte_to_mem, hd.b);
         chk("drain_half", half_word_to_mem, hd.h);
         chk("drain_sext", sign_extend_to_mem, 1'b0);
      end else if (!w) begin
         chk("mirror_addr", addr_to_mem, a);
         if (r) chk("load_data", data_to_proc, rd_word(1'b1, a));
      end
      stalled = stall_to_proc;
      @(posedge clock);
      if (exp_drain) begin
         mem_wr(1'b1, hd.a, hd.d, hd.b, hd.h);
         void'(q.pop_front());
      end
      if (exp_enq) q.push_back('{a, d, b, h});
      #1;
      chk("count", count, q.size());
      chk("empty", empty, (q.size() == 0));
   endtask

   // Repeat a request while stalled, as the processor holds it
   task automatic do_op(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d,
                        input logic b, input logic h, input logic s, output int stalls);
      logic st;
      logic done;
      stalls = 0;
      done = 1'b0;
      for (int k = 0; k < 12; k++) begin
         cyc(w, r, a, d, b, h, s, st);
         if (!st) begin done = 1'b1; break; end
         stalls++;
      end
      chk("op_done", done, 1'b1);
   endtask

   task automatic drain_all();
      logic st;
      for (int k = 0; k < 2 * DEPTH + 2 && q.size() > 0; k++) cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, st);
      chk("drained", empty, 1'b1);
   endtask

   initial begin
      int   stalls;
      logic st;
      logic [31:0] a, d;
      int   op, sz;
      for (int i = 0; i < 65536; i++) begin
         dut_mem[i] = 8'(i) ^ 8'h5A;
         ref_mem[i] = 8'(i) ^ 8'h5A;
      end
      reset = 1'b1;
      write_enable_from_proc = 1'b0; read_enable_from_proc = 1'b0;
      addr_from_proc = 32'h0000_3000; data_from_proc = 32'h0;
      byte_from_proc = 1'b0; half_word_from_proc = 1'b0; sign_extend_from_proc = 1'b0;
      data_from_mem = 32'h0;
      #3;
      chk("rst_count", count, 3'd0);
      chk("rst_empty", empty, 1'b1);
      chk("rst_wen", write_enable_to_mem, 1'b0);
      chk("rst_stall", stall_to_proc, 1'b0);
      chk("rst_mirror", addr_to_mem, 32'h0000_3000);
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;

      // Single store then idle
      do_op(1'b1, 1'b0, 32'h2000, 32'h1234_5678, 1'b0, 1'b0, 1'b0, stalls);
      cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, st);
      chk("single_mem", rd_word(1'b0, 32'h2000), 32'h1234_5678);

      // Fill: fifth store stalls once
      for (int k = 0; k < 5; k++) begin
         do_op(1'b1, 1'b0, 32'h2000 + 32'(k * 4), 32'hA000_0000 + 32'(k), 1'b0, 1'b0, 1'b0, stalls);
         if (k == 4) chk("fill_stalls", stalls, 32'd1);
      end
      chk("fill_count", count, 3'd4);
      drain_all();
      for (int k = 0; k < 5; k++) chk("fill_mem", rd_word(1'b0, 32'h2000 + 32'(k * 4)), 32'hA000_0000 + 32'(k));

      // RAW hazard: byte load hits the older pending store
      do_op(1'b1, 1'b0, 32'h2004, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, stalls);
      do_op(1'b1, 1'b0, 32'h2008, 32'hCAFE_F00D, 1'b0, 1'b0, 1'b0, stalls);
      do_op(1'b0, 1'b1, 32'h2006, 32'h0, 1'b1, 1'b0, 1'b0, stalls);
      chk("raw_stalls", stalls, 32'd1);
      chk("raw_count", count, 3'd1);
      chk("raw_byte", data_to_proc[16:23], 8'hBE);
      drain_all();

      // Bypass load with two pending stores, then simultaneous read+write
      do_op(1'b1, 1'b0, 32'h2010, 32'h1111_2222, 1'b0, 1'b0, 1'b0, stalls);
      do_op(1'b1, 1'b0, 32'h2014, 32'h3333_4444, 1'b0, 1'b0, 1'b0, stalls);
      do_op(1'b0, 1'b1, 32'h2100, 32'h0, 1'b0, 1'b0, 1'b0, stalls);
      chk("bypass_stalls", stalls, 32'd0);
      chk("bypass_count", count, 3'd2);
      do_op(1'b1, 1'b1, 32'h2018, 32'h5555_6666, 1'b0, 1'b0, 1'b0, stalls);
      chk("rw_count", count, 3'd3);
      drain_all();

      // Asynchronous reset with three stores queued: they are discarded
      for (int k = 0; k < 3; k++) do_op(1'b1, 1'b0, 32'h2020 + 32'(k * 4), 32'hBAD0_0000 + 32'(k), 1'b0, 1'b0, 1'b0, stalls);
      write_enable_from_proc = 1'b0;
      reset = 1'b1;
      #1;
      chk("mid_rst_count", count, 3'd0);
      chk("mid_rst_empty", empty, 1'b1);
      chk("mid_rst_wen", write_enable_to_mem, 1'b0);
      q.delete();
      @(posedge clock);
      #2 reset = 1'b0;
      for (int k = 0; k < 4; k++) cyc(1'b0, 1'b0, 32'h2020, 32'h0, 1'b0, 1'b0, 1'b0, st);
      chk("rst_discard", rd_word(1'b0, 32'h2020), rd_word(1'b1, 32'h2020));

      // Random traffic in a narrow window to provoke conflicts and fullness
      for (int n = 0; n < 300; n++) begin
         op = int'($urandom_range(0, 4));
         a  = 32'h2000 + 32'($urandom_range(0, 15) * 4);
         d  = $urandom;
         sz = int'($urandom_range(0, 2));
         if (sz == 1) a = a + 32'($urandom_range(0, 1) * 2);
         if (sz == 2) a = a + 32'($urandom_range(0, 3));
         case (op)
            0, 1: do_op(1'b1, 1'b0, a, d, sz == 2, sz == 1, 1'b0, stalls);
            2:    do_op(1'b0, 1'b1, a, d, sz == 2, sz == 1, 1'($urandom_range(0, 1)), stalls);
            3:    do_op(1'b1, 1'b1, a, d, sz == 2, sz == 1, 1'b0, stalls);
            default: cyc(1'b0, 1'b0, a, d, 1'b0, 1'b0, 1'b0, st);
         endcase
      end
      drain_all();
      for (int k = 0; k < 16; k++) chk("final_mem", rd_word(1'b0, 32'h2000 + 32'(k * 4)), rd_word(1'b1, 32'h2000 + 32'(k * 4)));

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule

// File: doc/dmem_store_buffer.md
# dmem_store_buffer

Posted-write buffer inserted between the processor's data-memory port and `dmem`. Stores are captured into a small FIFO in one cycle and retired to `dmem` in cycles when the processor is not using the data port. This frees the processor from waiting on memory writes. Loads bypass the buffer unless they hit a word still pending in it, in which case the processor is stalled until that word has drained.

## Interface
- `DEPTH`, 4, number of buffered stores; power of two, ≥2
- `CNT_W`, `$clog2(DEPTH+1)`, width of `count`
- `clock`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-high; clears all state
- `addr_from_proc`  in  [0:31]  processor byte address (bit 0 = MSB)
- `data_from_proc`  in  [0:31]  store data, same alignment `dmem` expects
- `write_enable_from_proc`  in  1  store request this cycle
- `read_enable_from_proc`  in  1  load request this cycle
- `byte_from_proc`, `half_word_from_proc`, `sign_extend_from_proc`  in  1 each  access size and sign qualifiers
- `data_to_proc`  out  [0:31]  load data; equals `data_from_mem` combinationally
- `stall_to_proc`  out  1  processor must hold its current memory request
- `addr_to_mem`, `data_to_mem`  out  [0:31]  dmem port
- `write_enable_to_mem`, `byte_to_mem`, `half_word_to_mem`, `sign_extend_to_mem`  out  1 each  dmem port
- `data_from_mem`  in  [0:31]  dmem read data
- `count`  out  CNT_W  registered occupancy
- `empty`  out  1  `count == 0`; the testbench waits on this before dumping memory

## Operation
- FIFO entry: {addr[0:31], data[0:31], byte, half_word}. Head pointer, tail pointer and count are registered. Pointers wrap modulo DEPTH.
- If write and read are asserted together, the cycle is treated as a write and the read is ignored.
- Word address is `addr[0:29]`. A load **conflicts** when any valid entry's word address equals the load's word address, regardless of size.
- Per-cycle decision, all combinational from the current state and inputs:
  - **Load, no conflict:** dmem port driven by the processor's address and size/sign, with `write_enable_to_mem=0`. `stall_to_proc=0`. No drain.
  - **Load, conflict:** `stall_to_proc=1`. Drain the head entry.
  - **Store, not full:** `stall_to_proc=0`. Enqueue at the clock edge. No drain.
  - **Store, full:** `stall_to_proc=1`. No enqueue. Drain the head entry.
  - **Idle, count>0:** drain the head entry.
  - **Idle, empty:** `write_enable_to_mem=0`. dmem port mirrors the processor inputs.
- Drain means the dmem port carries the head entry's addr, data, byte and half_word, with `sign_extend_to_mem=0` and `write_enable_to_mem=1`. The head pops at the same edge.
- `count_next = count + enq - deq`. Enqueue and dequeue never occur in the same cycle.
- Drains are strictly in FIFO order. A conflicting load stays stalled until every matching entry has drained, including any older non-matching entries ahead of them.

## Timing
- Reset, asynchronous: count=0, head=tail=0, empty=1. All entries are invalid; buffered stores are discarded, not written.
- Output values while in reset: `write_enable_to_mem=0`, `stall_to_proc=0`, and the dmem address/size outputs mirror the processor inputs.
- Store accepted in cycle N: visible in `count` from cycle N+1. The earliest dmem write is in cycle N+1, committed at the end of N+1.
- Conflicting load: `stall_to_proc` falls in the cycle after the edge that pops the last matching entry. The load then completes in that cycle with zero added latency.
- Non-conflicting load: 0 added cycles. `data_to_proc` follows `data_from_mem` in the same cycle.
- Full plus store: one stall cycle (drain). The store is accepted the next cycle.

## Test plan
- **Reset:** assert `reset` mid-cycle with 3 entries queued → immediately count=0, empty=1, `write_enable_to_mem=0`. After release, no dmem writes occur.
- **Single store:** store 0x12345678 to 0x2000, then idle → next cycle the dmem port shows addr 0x2000, data 0x12345678, `write_enable_to_mem=1`. The cycle after that, empty=1 and `mem[0x2000..0x2003]=12 34 56 78`.
- **Fill:** 5 back-to-back word stores to 0x2000–0x2010 → count reaches 4. The 5th sees `stall_to_proc=1` for 1 cycle while the 0x2000 store drains, then is accepted with count=4. After idling, all 5 words are in dmem in order.
- **RAW hazard:** stores to 0x2004 then 0x2008, then a byte load at 0x2006 → stall for 1 cycle (0x2004 drains). The load returns byte `mem[0x2006]` with the new value, and count=1.
- **Bypass load:** 2 stores pending, then a load from 0x2100 (no match) → `stall_to_proc=0`, data from dmem the same cycle, count unchanged at 2, `write_enable_to_mem=0` that cycle.
- **Simultaneous read and write:** both enables asserted → treated as a store, enqueued; no load is issued to dmem.
